// File: rtl/ex_mem_pipe_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_stage
//
// Pipeline register between EX and MEM. Each rising edge performs exactly one
// action, chosen by priority:
//   FLUSH   : exception flush, slot emptied and multi-cycle carry dropped
//   BUBBLE  : this stage stalled while the downstream stage runs, so a bubble
//             is pushed down; the carry loops back so EX keeps its
//             multi-cycle op alive
//   ADVANCE : normal transfer of the upstream slot (payload masked when the
//             slot is empty)
//   HOLD    : this stage and the downstream stage are both stalled, so the
//             slot is kept and the carry loops back
// Two saturating counters record how many BUBBLE and HOLD edges occurred.
//
// Parameters
//   DW      payload width
//   CW      multi-cycle carry width ({hilo, cnt})
//   STALL_W stall vector width
//   STAGE   index of this stage in the stall vector (0..STALL_W-1)
//   CNT_W   statistics counter width
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   stall       pipeline stall vector, 1 = stop
//   flush       exception flush
//   in_valid    upstream slot holds a real instruction
//   in_payload  upstream stage data
//   carry_i     multi-cycle operation state from EX
//   clr_cnt     synchronous clear of both counters
//   out_valid   registered valid
//   out_payload registered payload
//   carry_o     registered carry returned to EX
//   bubble_cnt  number of bubbles inserted (saturating)
//   hold_cnt    number of cycles held (saturating)
// ---------------------------------------------------------------------------
module ex_mem_pipe_stage #(
  parameter int unsigned DW      = 32,
  parameter int unsigned CW      = 66,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned STAGE   = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DW-1:0]      in_payload,
  input  logic [CW-1:0]      carry_i,
  input  logic               clr_cnt,
  output logic               out_valid,
  output logic [DW-1:0]      out_payload,
  output logic [CW-1:0]      carry_o,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt
);

  typedef enum logic [1:0] {
    ActFlush,
    ActBubble,
    ActAdvance,
    ActHold
  } action_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  // Only stall[STAGE] and stall[STAGE+1] matter; the rest is deliberately unused.
  logic unused_stall;
  assign unused_stall = ^stall;

  // ------------------------------------------------------------------------
  // Downstream stop: the last stage has nobody below it, so it never sees one.
  // ------------------------------------------------------------------------
  logic down_stop;

  generate
    if (STAGE < STALL_W - 1) begin : g_down_stop
      assign down_stop = stall[STAGE+1];
    end else begin : g_last_stage
      assign down_stop = 1'b0;
    end
  endgenerate

  logic self_stop;
  assign self_stop = stall[STAGE];

  // ------------------------------------------------------------------------
  // Action select
  // ------------------------------------------------------------------------
  action_e action;

  always_comb begin
    action = ActHold;
    if (flush) begin
      action = ActFlush;
    end else if (self_stop && !down_stop) begin
      action = ActBubble;
    end else if (!self_stop) begin
      action = ActAdvance;
    end
  end

  // ------------------------------------------------------------------------
  // Slot and carry next state
  // ------------------------------------------------------------------------
  logic          valid_d,   valid_q;
  logic [DW-1:0] payload_d, payload_q;
  logic [CW-1:0] carry_d,   carry_q;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    carry_d   = '0;
    unique case (action)
      ActFlush: begin
        valid_d   = 1'b0;
        payload_d = '0;
        carry_d   = '0;
      end
      ActBubble: begin
        valid_d   = 1'b0;
        payload_d = '0;
        carry_d   = carry_i;
      end
      ActAdvance: begin
        valid_d   = in_valid;
        // An empty slot must never leak stale upstream data downstream.
        payload_d = in_valid ? in_payload : '0;
        carry_d   = '0;
      end
      ActHold: begin
        carry_d   = carry_i;
      end
      default: begin
        valid_d   = 1'b0;
        payload_d = '0;
        carry_d   = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Statistics counters: clear beats increment, flush never counts.
  // ------------------------------------------------------------------------
  logic [CNT_W-1:0] bubble_d, bubble_q;
  logic [CNT_W-1:0] hold_d,   hold_q;

  always_comb begin
    bubble_d = bubble_q;
    hold_d   = hold_q;
    if (clr_cnt) begin
      bubble_d = '0;
      hold_d   = '0;
    end else begin
      if (action == ActBubble && bubble_q != CntMax) begin
        bubble_d = bubble_q + CNT_W'(1);
      end
      if (action == ActHold && hold_q != CntMax) begin
        hold_d = hold_q + CNT_W'(1);
      end
    end
  end

  // ------------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      carry_q   <= '0;
      bubble_q  <= '0;
      hold_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      carry_q   <= carry_d;
      bubble_q  <= bubble_d;
      hold_q    <= hold_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_payload = payload_q;
  assign carry_o     = carry_q;
  assign bubble_cnt  = bubble_q;
  assign hold_cnt    = hold_q;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage. Three instances share one set of inputs:
//   u0 default parameters, u1 CNT_W=4 (saturation), u2 STAGE=5 (last stage).
// A rule-level model tracks each instance; directed steps come first, then
// randomized traffic with occasional asynchronous resets.
module tb_ex_mem_pipe_stage;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_payload;
  logic [65:0] carry_i;
  logic        clr_cnt;

  logic        ov [NI];
  logic [31:0] op [NI];
  logic [65:0] oc [NI];
  logic [15:0] ob0, oh0, ob2, oh2;
  logic [3:0]  ob1, oh1;

  ex_mem_pipe_stage u0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_payload(in_payload), .carry_i(carry_i), .clr_cnt(clr_cnt),
    .out_valid(ov[0]), .out_payload(op[0]), .carry_o(oc[0]),
    .bubble_cnt(ob0), .hold_cnt(oh0)
  );

  ex_mem_pipe_stage #(.CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_payload(in_payload), .carry_i(carry_i), .clr_cnt(clr_cnt),
    .out_valid(ov[1]), .out_payload(op[1]), .carry_o(oc[1]),
    .bubble_cnt(ob1), .hold_cnt(oh1)
  );

  ex_mem_pipe_stage #(.STAGE(5)) u2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_payload(in_payload), .carry_i(carry_i), .clr_cnt(clr_cnt),
    .out_valid(ov[2]), .out_payload(op[2]), .carry_o(oc[2]),
    .bubble_cnt(ob2), .hold_cnt(oh2)
  );

  // Reference model state
  int          stage_of [NI] = '{3, 3, 5};
  int          cnt_max  [NI] = '{65535, 15, 65535};
  logic        m_valid   [NI];
  logic [31:0] m_payload [NI];
  logic [65:0] m_carry   [NI];
  int          m_bub     [NI];
  int          m_hold    [NI];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_valid[k]   = 1'b0;
      m_payload[k] = '0;
      m_carry[k]   = '0;
      m_bub[k]     = 0;
      m_hold[k]    = 0;
    end
  endtask

  // One rising edge of every instance, from the action rules.
  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      bit mine  = stall[stage_of[k]];
      bit below = (stage_of[k] < 5) ? stall[stage_of[k] + 1] : 1'b0;
      if (clr_cnt) begin
        m_bub[k]  = 0;
        m_hold[k] = 0;
      end
      if (flush) begin
        m_valid[k]   = 1'b0;
        m_payload[k] = '0;
        m_carry[k]   = '0;
      end else if (mine && !below) begin
        m_valid[k]   = 1'b0;
        m_payload[k] = '0;
        m_carry[k]   = carry_i;
        if (!clr_cnt && m_bub[k] < cnt_max[k]) m_bub[k]++;
      end else if (!mine) begin
        m_valid[k]   = in_valid;
        m_payload[k] = in_valid ? in_payload : 32'h0;
        m_carry[k]   = '0;
      end else begin
        m_carry[k]   = carry_i;
        if (!clr_cnt && m_hold[k] < cnt_max[k]) m_hold[k]++;
      end
    end
  endtask

  task automatic check_inst(input string tag, input int k, input logic v,
                            input logic [31:0] p, input logic [65:0] c,
                            input logic [31:0] b, input logic [31:0] h);
    chk($sformatf("%s u%0d valid", tag, k), v, m_valid[k]);
    chk($sformatf("%s u%0d payload", tag, k), p, m_payload[k]);
    chk($sformatf("%s u%0d carry", tag, k), c, m_carry[k]);
    chk($sformatf("%s u%0d bubble_cnt", tag, k), b, 32'(m_bub[k]));
    chk($sformatf("%s u%0d hold_cnt", tag, k), h, 32'(m_hold[k]));
  endtask

  task automatic check_all(input string tag);
    check_inst(tag, 0, ov[0], op[0], oc[0], 32'(ob0), 32'(oh0));
    check_inst(tag, 1, ov[1], op[1], oc[1], 32'(ob1), 32'(oh1));
    check_inst(tag, 2, ov[2], op[2], oc[2], 32'(ob2), 32'(oh2));
  endtask

  // Drive inputs, let one edge happen, check on the following falling edge.
  task automatic step(input logic [5:0] s, input logic f, input logic v,
                      input logic [31:0] p, input logic [65:0] c, input logic clr,
                      input string tag);
    stall      = s;
    flush      = f;
    in_valid   = v;
    in_payload = p;
    carry_i    = c;
    clr_cnt    = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  // Called at a falling edge: reset pulse strictly between rising edges.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all(tag);
    #1 rst = 1'b1;
  endtask

  logic [95:0] r96;

  initial begin
    rst        = 1'b0;
    stall      = '0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_payload = '0;
    carry_i    = '0;
    clr_cnt    = 1'b0;
    model_reset();

    // Reset must dominate busy inputs across edges.
    @(negedge clk);
    in_valid   = 1'b1;
    in_payload = 32'hFFFF_FFFF;
    carry_i    = '1;
    @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b1;

    // Advance
    step(6'b000000, 1'b0, 1'b1, 32'hDEAD_BEEF, 66'h0, 1'b0, "adv");
    chk("adv payload const", op[0], 32'hDEAD_BEEF);
    chk("adv valid const", ov[0], 1'b1);

    // Empty slot masks payload
    step(6'b000000, 1'b0, 1'b0, 32'h1357_9BDF, 66'h5, 1'b0, "adv_empty");
    chk("adv_empty payload const", op[0], 32'h0);

    // Bubble with carry loopback
    step(6'b001111, 1'b0, 1'b1, 32'h1111_2222, 66'h1_2345, 1'b0, "bubble");
    chk("bubble carry const", oc[0], 66'h1_2345);
    chk("bubble cnt const", ob0, 16'd1);

    // Hold: load then three held edges
    step(6'b000000, 1'b0, 1'b1, 32'hA5A5_0001, 66'h0, 1'b1, "load");
    for (int i = 0; i < 3; i++) begin
      step(6'b011111, 1'b0, 1'b1, $urandom, 66'(i + 7), 1'b0, "hold");
    end
    chk("hold payload const", op[0], 32'hA5A5_0001);
    chk("hold cnt const", oh0, 16'd3);

    // Flush beats stall and does not count
    step(6'b001111, 1'b1, 1'b1, 32'h4444_5555, 66'h3, 1'b0, "flush");
    chk("flush valid const", ov[0], 1'b0);
    chk("flush carry const", oc[0], 66'h0);
    chk("flush bubble const", ob0, 16'd0);

    // Saturation on the 4-bit instance, then clear during a bubble
    for (int i = 0; i < 20; i++) begin
      step(6'b001111, 1'b0, 1'b1, $urandom, 66'(i), 1'b0, "sat");
    end
    chk("sat u1 const", ob1, 4'hF);
    chk("sat u0 const", ob0, 16'd20);
    step(6'b001111, 1'b0, 1'b1, $urandom, 66'h9, 1'b1, "clr");
    chk("clr u1 const", ob1, 4'h0);

    // Asynchronous reset in the middle of a hold
    step(6'b000000, 1'b0, 1'b1, 32'h0000_0077, 66'h0, 1'b0, "load2");
    step(6'b011111, 1'b0, 1'b1, 32'h0000_0088, 66'h2_AAAA, 1'b0, "hold2");
    async_reset("async_rst");
    chk("async_rst payload const", op[0], 32'h0);
    chk("async_rst carry const", oc[0], 66'h0);

    // Last stage: stall[5] alone is a bubble for STAGE=5, an advance elsewhere
    step(6'b100000, 1'b0, 1'b1, 32'h0BAD_F00D, 66'h6_0000, 1'b0, "stage5");
    chk("stage5 u2 valid const", ov[2], 1'b0);
    chk("stage5 u2 bubble const", ob2, 16'd1);
    chk("stage5 u0 payload const", op[0], 32'h0BAD_F00D);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      r96 = {$urandom, $urandom, $urandom};
      step(6'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom), $urandom,
           r96[65:0], ($urandom_range(0, 15) == 0), "rand");
      if ($urandom_range(0, 63) == 0) async_reset("rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe_stage.md
EX_MEM_PIPE_STAGE -- requirements
Module: ex_mem_pipe_stage

Interface
REQ-001 The block SHALL have a parameter DW, default 32: payload width in bits (aluop/addr/data/wd/wreg fields packed by the instantiator).
REQ-002 The block SHALL have a parameter CW, default 66: multi-cycle carry width in bits ({hilo, cnt}).
REQ-003 The block SHALL have a parameter STALL_W, default 6: stall vector width.
REQ-004 The block SHALL have a parameter STAGE, default 3: the index of this stage in the stall vector; 0 <= STAGE <= STALL_W-1.
REQ-005 The block SHALL have a parameter CNT_W, default 16: width of each statistics counter.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port stall, input, STALL_W bits: pipeline stall vector, 1 = Stop.
REQ-009 The block SHALL have port flush, input, 1 bit: exception flush.
REQ-010 The block SHALL have port in_valid, input, 1 bit: the upstream slot holds a real instruction.
REQ-011 The block SHALL have port in_payload, input, DW bits: upstream stage data.
REQ-012 The block SHALL have port carry_i, input, CW bits: multi-cycle operation state from EX.
REQ-013 The block SHALL have port clr_cnt, input, 1 bit: synchronous counter clear.
REQ-014 The block SHALL have port out_valid, output, 1 bit: registered valid.
REQ-015 The block SHALL have port out_payload, output, DW bits: registered payload.
REQ-016 The block SHALL have port carry_o, output, CW bits: registered carry returned to EX.
REQ-017 The block SHALL have port bubble_cnt, output, CNT_W bits: bubbles inserted.
REQ-018 The block SHALL have port hold_cnt, output, CNT_W bits: cycles held.

Function
REQ-019 Signal down_stop SHALL equal stall[STAGE+1] when STAGE < STALL_W-1, and SHALL be constant 0 when STAGE = STALL_W-1.
REQ-020 On each edge, the block SHALL select exactly one action by priority: FLUSH (flush=1) > BUBBLE (stall[STAGE]=1 and down_stop=0) > ADVANCE (stall[STAGE]=0) > HOLD (stall[STAGE]=1 and down_stop=1).
REQ-021 In FLUSH, the block SHALL set out_valid<=0, out_payload<=0 and carry_o<=0.
REQ-022 In BUBBLE, the block SHALL set out_valid<=0 and out_payload<=0, and SHALL set carry_o<=carry_i so the multi-cycle op continues.
REQ-023 In ADVANCE, the block SHALL set out_valid<=in_valid and out_payload<=(in_valid ? in_payload : 0), and SHALL set carry_o<=0.
REQ-024 In HOLD, out_valid and out_payload SHALL be unchanged, and the block SHALL set carry_o<=carry_i.
REQ-025 Latency SHALL be 1 cycle from input to output in ADVANCE; there SHALL be no combinational path from any input to any output.
REQ-026 bubble_cnt SHALL increment by 1 on every BUBBLE edge, saturating at 2^CNT_W-1, with no wrap.
REQ-027 hold_cnt SHALL increment by 1 on every HOLD edge, saturating at 2^CNT_W-1.
REQ-028 When clr_cnt=1, both counters SHALL be set to 0 on that edge; clear SHALL win over a simultaneous increment.
REQ-029 FLUSH SHALL NOT change either counter; a FLUSH cycle SHALL NOT count as a bubble or a hold even if the stall condition is also true.
REQ-030 An in_payload with in_valid=0 SHALL never appear on out_payload.

Reset
REQ-031 When rst=0, all outputs SHALL go to 0 immediately, independent of clk: out_valid=0, out_payload=0, carry_o=0, bubble_cnt=0, hold_cnt=0.
REQ-032 Deassertion of rst SHALL take effect at the next rising edge; the first edge with rst=1 SHALL evaluate REQ-020 normally.
REQ-033 Reset asserted mid-HOLD or mid-multi-cycle SHALL discard the held payload and the carry.

Verification
REQ-034 The bench SHALL cover advance: stall=6'b000000, in_valid=1, in_payload=32'hDEAD_BEEF -> next edge out_valid=1, out_payload=32'hDEAD_BEEF, carry_o=0.
REQ-035 The bench SHALL cover bubble: stall=6'b001111, carry_i=66'h1_2345 -> out_valid=0, out_payload=0, carry_o=66'h1_2345, bubble_cnt +1.
REQ-036 The bench SHALL cover hold: load payload 32'hA5A5_0001, then stall=6'b011111 for 3 edges -> out_payload stays 32'hA5A5_0001, out_valid=1, hold_cnt=3.
REQ-037 The bench SHALL cover flush over stall: flush=1 with stall=6'b001111 -> out_valid=0, carry_o=0, bubble_cnt unchanged.
REQ-038 The bench SHALL cover saturation and clear: CNT_W=4 with 20 bubble cycles -> bubble_cnt=4'hF; then clr_cnt=1 during a bubble -> bubble_cnt=0.
REQ-039 The bench SHALL cover asynchronous reset: drop rst between edges during HOLD -> all outputs 0 before the next edge; STAGE=5 with stall=6'b100000 -> BUBBLE.
